// File: rtl/ahb_lite_master.sv
// AHB-Lite bus master: turns single commands into SINGLE/INCR4/8/16 transfers,
// handling wait states, the two-cycle ERROR response and 1 KB boundary restarts.
module ahb_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              done_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);

    localparam logic [2:0] MAX_SIZE  = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LAST, S_ERR, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_out_of_rst;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_beats;
    logic              r_nonseq;
    logic              r_write;
    logic [2:0]        r_size;
    logic [2:0]        r_hburst;
    logic [DATA_W-1:0] r_hwdata;
    logic              r_dphase;
    logic              r_dwrite;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err;

    logic [1:0]        w_htrans;
    logic              w_accept;
    logic              w_dp_err;
    logic              w_rd_ok;
    logic              w_cmd_take;
    logic              w_size_bad;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [4:0]        w_beats;
    logic [2:0]        w_hburst;

    assign w_dp_err   = r_dphase && HRESP;
    assign w_rd_ok    = r_dphase && !r_dwrite && HREADY && !HRESP;
    assign w_cmd_take = (r_state == S_IDLE) && r_out_of_rst && cmd_valid;
    assign w_size_bad = cmd_size > MAX_SIZE;
    assign w_addr_inc = r_addr + (ADDR_W'(1) << r_size);
    assign w_accept   = (w_htrans != TR_IDLE) && HREADY;

    always_comb begin
        w_beats  = 5'd1;
        w_hburst = 3'b000;
        case (cmd_burst)
            2'd1:    begin w_beats = 5'd4;  w_hburst = 3'b011; end
            2'd2:    begin w_beats = 5'd8;  w_hburst = 3'b101; end
            2'd3:    begin w_beats = 5'd16; w_hburst = 3'b111; end
            default: begin w_beats = 5'd1;  w_hburst = 3'b000; end
        endcase
    end

    // An ERROR in the data phase cancels the pending address beat in the same cycle.
    always_comb begin
        w_next   = r_state;
        w_htrans = TR_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_take) w_next = w_size_bad ? S_DONE : S_ADDR;
            end
            S_ADDR: begin
                if (w_dp_err) begin
                    w_next = HREADY ? S_DONE : S_ERR;
                end else begin
                    w_htrans = r_nonseq ? TR_NONSEQ : TR_SEQ;
                    if (HREADY && r_beats == 5'd1) w_next = S_LAST;
                end
            end
            S_LAST: begin
                if (w_dp_err)    w_next = HREADY ? S_DONE : S_ERR;
                else if (HREADY) w_next = S_DONE;
            end
            S_ERR: begin
                if (HREADY && HRESP) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_out_of_rst <= 1'b0;
            r_addr       <= '0;
            r_beats      <= '0;
            r_nonseq     <= 1'b0;
            r_write      <= 1'b0;
            r_size       <= '0;
            r_hburst     <= '0;
            r_hwdata     <= '0;
            r_dphase     <= 1'b0;
            r_dwrite     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_out_of_rst <= 1'b1;
            r_rd_valid   <= w_rd_ok;
            if (w_rd_ok) r_rd_data <= HRDATA;

            if (w_cmd_take) begin
                r_err <= w_size_bad;
                if (!w_size_bad) begin
                    r_addr   <= cmd_addr;
                    r_write  <= cmd_write;
                    r_size   <= cmd_size;
                    r_hburst <= w_hburst;
                    r_beats  <= w_beats;
                    r_nonseq <= 1'b1;
                end
            end

            if (w_accept) begin
                r_addr   <= w_addr_inc;
                r_beats  <= r_beats - 5'd1;
                r_nonseq <= 1'b0;
                // Crossing a 1 KB page restarts the rest of the burst as undefined-length INCR.
                if (w_addr_inc[9:0] == '0) begin
                    r_nonseq <= 1'b1;
                    r_hburst <= 3'b001;
                end
                if (r_write) r_hwdata <= wr_data;
                r_dphase <= 1'b1;
                r_dwrite <= r_write;
            end else if (HREADY) begin
                r_dphase <= 1'b0;
            end

            if (w_dp_err && (r_state == S_ADDR || r_state == S_LAST)) r_err <= 1'b1;
        end
    end

    assign cmd_ready = (r_state == S_IDLE) && r_out_of_rst;
    assign wr_pop    = w_accept && r_write;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = (r_state == S_DONE);
    assign done_err  = (r_state == S_DONE) && r_err;
    assign HADDR     = r_addr;
    assign HTRANS    = w_htrans;
    assign HWRITE    = r_write;
    assign HSIZE     = r_size;
    assign HBURST    = r_hburst;
    assign HWDATA    = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small scripted AHB slave model
// (configurable wait states, error on a chosen beat, read data = 0xC0DE0000 ^ address).
module tb_ahb_lite_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        done_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .done_err(done_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int nvec = 0;
    int nerr = 0;

    // slave model state
    int          cfg_waits;
    int          cfg_err_beat;
    int          s_beat;
    int          s_cnt;
    logic        s_dp;
    logic        s_write;
    logic [31:0] s_addr;
    logic        l_hready;
    logic        l_valid;
    logic        l_write;
    logic [31:0] l_addr;
    logic [31:0] slv_wd [256];

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            s_dp = 1'b0; s_cnt = 0; s_beat = 0; s_write = 1'b0; s_addr = '0;
            l_hready = 1'b1; l_valid = 1'b0; l_addr = '0; l_write = 1'b0;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        end else begin
            if (l_hready) begin
                s_dp = l_valid;
                if (l_valid) begin
                    s_addr = l_addr; s_write = l_write; s_beat = s_beat + 1; s_cnt = 0;
                end
            end else begin
                s_cnt = s_cnt + 1;
            end
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
            if (s_dp) begin
                if (s_beat == cfg_err_beat) begin
                    HRESP  = 1'b1;
                    HREADY = (s_cnt >= 1);
                end else begin
                    HREADY = (s_cnt >= cfg_waits);
                    if (!s_write) HRDATA = 32'hC0DE_0000 ^ s_addr;
                end
            end
            #1;
            if (s_dp && s_write && HREADY && !HRESP) slv_wd[s_beat % 256] = HWDATA;
            l_hready = HREADY;
            l_valid  = (HTRANS != 2'b00);
            l_addr   = HADDR;
            l_write  = HWRITE;
        end
    end

    // per-cycle record of one command, index = cycles after the accepting edge
    logic [1:0]  tr  [64];
    logic [31:0] ad  [64];
    logic [2:0]  bu  [64];
    logic [2:0]  hs  [64];
    logic        hwr [64];
    logic [31:0] hw  [64];
    logic        rv  [64];
    logic [31:0] rd  [64];
    logic        de  [64];
    logic        rdy [64];
    logic        sd  [64];
    int          n_pop, n_rdv, done_cyc, base;
    logic        rdy0;

    task automatic step();
        @(negedge HCLK);
        #2;
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [1:0] burst, input int waits, input int err_rel,
                           input logic [31:0] wbase);
        for (int i = 0; i < 64; i++) begin
            tr[i] = 'x; ad[i] = 'x; bu[i] = 'x; hs[i] = 'x; hwr[i] = 'x; hw[i] = 'x;
            rv[i] = 'x; rd[i] = 'x; de[i] = 'x; rdy[i] = 'x; sd[i] = 'x;
        end
        base         = s_beat;
        cfg_waits    = waits;
        cfg_err_beat = (err_rel == 0) ? 0 : base + err_rel;
        n_pop = 0; n_rdv = 0; done_cyc = -1;
        cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_burst = burst;
        wr_data = wbase;
        cmd_valid = 1'b1;
        rdy0 = cmd_ready;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c < 40; c++) begin
            wr_data = wbase + 32'(n_pop);
            tr[c] = HTRANS; ad[c] = HADDR; bu[c] = HBURST; hs[c] = HSIZE; hwr[c] = HWRITE;
            hw[c] = HWDATA; rv[c] = rd_valid; rd[c] = rd_data; de[c] = done_err;
            rdy[c] = cmd_ready; sd[c] = s_dp;
            if (wr_pop) n_pop++;
            if (rd_valid) n_rdv++;
            if (done && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c >= done_cyc + 1) break;
            step();
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        step();
        step();
        nvec++; if (HTRANS !== 2'b00)  begin nerr++; $display("FAIL rst_htrans got=%h exp=0", HTRANS); end
        nvec++; if (HADDR !== 32'h0)   begin nerr++; $display("FAIL rst_haddr got=%h exp=0", HADDR); end
        nvec++; if (HWDATA !== 32'h0)  begin nerr++; $display("FAIL rst_hwdata got=%h exp=0", HWDATA); end
        nvec++; if (rd_data !== 32'h0) begin nerr++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
        nvec++; if ({HWRITE, HSIZE, HBURST} !== 7'h0) begin nerr++; $display("FAIL rst_ctrl got=%h exp=0", {HWRITE, HSIZE, HBURST}); end
        nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
        nvec++; if ({wr_pop, rd_valid, done, done_err} !== 4'h0) begin nerr++; $display("FAIL rst_pulses got=%b exp=0000", {wr_pop, rd_valid, done, done_err}); end
        HRESETn = 1'b1;
        step();
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_single_write();
        run_cmd(1'b1, 32'h0000_0040, 3'd2, 2'd0, 2, 0, 32'hDEAD_BEEF);
        nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL sw_ready_at_issue got=%b exp=1", rdy0); end
        nvec++; if (tr[1] !== 2'b10) begin nerr++; $display("FAIL sw_nonseq got=%h exp=2", tr[1]); end
        nvec++; if ({ad[1], hwr[1], hs[1], bu[1]} !== {32'h40, 1'b1, 3'd2, 3'd0}) begin nerr++; $display("FAIL sw_ctrl got=%h exp=%h", {ad[1], hwr[1], hs[1], bu[1]}, {32'h40, 1'b1, 3'd2, 3'd0}); end
        nvec++; if (tr[2] !== 2'b00) begin nerr++; $display("FAIL sw_nonseq_once got=%h exp=0", tr[2]); end
        for (int c = 2; c <= 4; c++) begin
            nvec++; if ({sd[c], hw[c]} !== {1'b1, 32'hDEAD_BEEF}) begin nerr++; $display("FAIL sw_hwdata c=%0d got=%b/%h exp=1/deadbeef", c, sd[c], hw[c]); end
        end
        nvec++; if (n_pop !== 1) begin nerr++; $display("FAIL sw_wr_pop got=%0d exp=1", n_pop); end
        nvec++; if (done_cyc !== 5) begin nerr++; $display("FAIL sw_done_cycle got=%0d exp=5", done_cyc); end
        nvec++; if (de[5] !== 1'b0) begin nerr++; $display("FAIL sw_done_err got=%b exp=0", de[5]); end
        nvec++; if (rdy[6] !== 1'b1) begin nerr++; $display("FAIL sw_ready_after got=%b exp=1", rdy[6]); end
        nvec++; if (slv_wd[(base + 1) % 256] !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL sw_slave_data got=%h exp=deadbeef", slv_wd[(base + 1) % 256]); end
    endtask

    task automatic test_incr4_read();
        logic [31:0] exp_a [4];
        logic [31:0] exp_d [4];
        exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
        exp_d = '{32'hC0DE_0100, 32'hC0DE_0104, 32'hC0DE_0108, 32'hC0DE_010C};
        run_cmd(1'b0, 32'h100, 3'd2, 2'd1, 0, 0, 32'h0);
        for (int b = 0; b < 4; b++) begin
            nvec++; if ({tr[b+1], ad[b+1], bu[b+1]} !== {(b == 0) ? 2'b10 : 2'b11, exp_a[b], 3'b011}) begin nerr++; $display("FAIL i4_addr_beat b=%0d got=%h/%h/%h exp_addr=%h", b, tr[b+1], ad[b+1], bu[b+1], exp_a[b]); end
            nvec++; if ({rv[b+3], rd[b+3]} !== {1'b1, exp_d[b]}) begin nerr++; $display("FAIL i4_rd b=%0d got=%b/%h exp=1/%h", b, rv[b+3], rd[b+3], exp_d[b]); end
        end
        nvec++; if (tr[5] !== 2'b00) begin nerr++; $display("FAIL i4_idle_after got=%h exp=0", tr[5]); end
        nvec++; if (n_rdv !== 4) begin nerr++; $display("FAIL i4_rd_count got=%0d exp=4", n_rdv); end
        nvec++; if (done_cyc !== 6 || de[6] !== 1'b0) begin nerr++; $display("FAIL i4_done got=%0d/%b exp=6/0", done_cyc, de[6]); end
        run_cmd(1'b0, 32'h180, 3'd2, 2'd1, 1, 0, 32'h0);
        nvec++; if ({tr[2], ad[2], tr[3], ad[3]} !== {2'b11, 32'h184, 2'b11, 32'h184}) begin nerr++; $display("FAIL i4w_hold got=%h/%h %h/%h exp=3/184 3/184", tr[2], ad[2], tr[3], ad[3]); end
        nvec++; if (n_rdv !== 4 || done_cyc !== 10) begin nerr++; $display("FAIL i4w_done got=%0d/%0d exp=4/10", n_rdv, done_cyc); end
    endtask

    task automatic test_incr8_boundary();
        logic [31:0] exp_a [8];
        logic [1:0]  exp_t [8];
        logic [2:0]  exp_b [8];
        exp_a = '{32'h3F8, 32'h3FC, 32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h414};
        exp_t = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        exp_b = '{3'b101, 3'b101, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        run_cmd(1'b1, 32'h3F8, 3'd2, 2'd2, 0, 0, 32'h1000_0000);
        for (int b = 0; b < 8; b++) begin
            nvec++; if ({tr[b+1], ad[b+1], bu[b+1]} !== {exp_t[b], exp_a[b], exp_b[b]}) begin nerr++; $display("FAIL i8_beat b=%0d got=%h/%h/%h exp=%h/%h/%h", b, tr[b+1], ad[b+1], bu[b+1], exp_t[b], exp_a[b], exp_b[b]); end
            nvec++; if (hw[b+2] !== 32'h1000_0000 + 32'(b)) begin nerr++; $display("FAIL i8_hwdata b=%0d got=%h exp=%h", b, hw[b+2], 32'h1000_0000 + 32'(b)); end
        end
        nvec++; if (n_pop !== 8) begin nerr++; $display("FAIL i8_wr_pop got=%0d exp=8", n_pop); end
        nvec++; if (slv_wd[(base + 8) % 256] !== 32'h1000_0007) begin nerr++; $display("FAIL i8_slave_last got=%h exp=10000007", slv_wd[(base + 8) % 256]); end
        nvec++; if (done_cyc !== 10 || de[10] !== 1'b0) begin nerr++; $display("FAIL i8_done got=%0d/%b exp=10/0", done_cyc, de[10]); end
    endtask

    task automatic test_incr16_error();
        run_cmd(1'b0, 32'h200, 3'd2, 2'd3, 0, 3, 32'h0);
        nvec++; if ({tr[1], tr[2], tr[3], ad[3]} !== {2'b10, 2'b11, 2'b11, 32'h208}) begin nerr++; $display("FAIL i16_beats got=%h %h %h/%h", tr[1], tr[2], tr[3], ad[3]); end
        for (int c = 4; c <= 7; c++) begin
            nvec++; if (tr[c] !== 2'b00) begin nerr++; $display("FAIL i16_cancel c=%0d got=%h exp=0", c, tr[c]); end
        end
        nvec++; if (n_rdv !== 2) begin nerr++; $display("FAIL i16_rd_count got=%0d exp=2", n_rdv); end
        nvec++; if ({rd[3], rd[4]} !== {32'hC0DE_0200, 32'hC0DE_0204}) begin nerr++; $display("FAIL i16_rd_data got=%h %h exp=c0de0200 c0de0204", rd[3], rd[4]); end
        nvec++; if (done_cyc !== 6 || de[6] !== 1'b1) begin nerr++; $display("FAIL i16_done got=%0d/%b exp=6/1", done_cyc, de[6]); end
    endtask

    task automatic test_size_error();
        run_cmd(1'b0, 32'h40, 3'd3, 2'd0, 0, 0, 32'h0);
        nvec++; if (done_cyc !== 1 || de[1] !== 1'b1) begin nerr++; $display("FAIL sz_done got=%0d/%b exp=1/1", done_cyc, de[1]); end
        nvec++; if ({tr[1], tr[2]} !== 4'h0) begin nerr++; $display("FAIL sz_no_bus got=%h exp=0", {tr[1], tr[2]}); end
        nvec++; if (rdy[2] !== 1'b1) begin nerr++; $display("FAIL sz_ready got=%b exp=1", rdy[2]); end
    endtask

    task automatic test_reset_midburst();
        int ndone = 0;
        cfg_waits = 0; cfg_err_beat = 0;
        cmd_write = 1'b1; cmd_addr = 32'h500; cmd_size = 3'd2; cmd_burst = 2'd2;
        wr_data = 32'h5555_AAAA;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (done) ndone++;
            step();
        end
        nvec++; if ({HTRANS, HADDR} !== {2'b11, 32'h510}) begin nerr++; $display("FAIL mr_beat5 got=%h/%h exp=3/510", HTRANS, HADDR); end
        HRESETn = 1'b0;
        #1;
        nvec++; if ({HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST} !== 73'h0) begin nerr++; $display("FAIL mr_bus_reset got=%h/%h/%h/%b/%h/%h exp=0", HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST); end
        nvec++; if ({cmd_ready, wr_pop, rd_valid, done, done_err} !== 5'h0) begin nerr++; $display("FAIL mr_ctl_reset got=%b exp=00000", {cmd_ready, wr_pop, rd_valid, done, done_err}); end
        for (int c = 0; c < 3; c++) begin
            step();
            if (done) ndone++;
        end
        HRESETn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done) ndone++;
        end
        nvec++; if (ndone !== 0) begin nerr++; $display("FAIL mr_no_done got=%0d exp=0", ndone); end
        run_cmd(1'b0, 32'h80, 3'd2, 2'd0, 0, 0, 32'h0);
        nvec++; if ({rdy0, tr[1], ad[1]} !== {1'b1, 2'b10, 32'h80}) begin nerr++; $display("FAIL mr_restart got=%b/%h/%h exp=1/2/80", rdy0, tr[1], ad[1]); end
        nvec++; if ({rv[3], rd[3]} !== {1'b1, 32'hC0DE_0080}) begin nerr++; $display("FAIL mr_rd got=%b/%h exp=1/c0de0080", rv[3], rd[3]); end
        nvec++; if (done_cyc !== 3 || de[3] !== 1'b0) begin nerr++; $display("FAIL mr_done got=%0d/%b exp=3/0", done_cyc, de[3]); end
    endtask

    initial begin
        HRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_burst = '0;
        wr_data = '0; cfg_waits = 0; cfg_err_beat = 0;
        test_reset();
        test_single_write();
        step();
        test_incr4_read();
        step();
        test_incr8_boundary();
        step();
        test_incr16_error();
        step();
        test_size_error();
        step();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
